// File: rtl/image_pkg.sv
// Shared types for the frame capture/replay path.
// Exports default frame geometry, the {r,g,b} pixel word and the
// buffer's operating states.
package image_pkg;

    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        CAPTURE,
        FULL,
        REPLAY
    } state_t;

endpackage

// File: rtl/frame_replay_buffer_if.sv
// Pixel bus bundle for frame_replay_buffer.
// Input side : in_valid, rowIndex, colIndex, DATA_R0/G0/B0 (indexed pixel stream)
// Output side: out_valid/out_ready handshake, out_row, out_col, out_R/G/B
// master = producer of input pixels / consumer of replayed pixels
// slave  = the buffer itself
interface frame_replay_buffer_if #(
    parameter int BITS_FOR_INDEX = 10
);
    logic                      in_valid;
    logic [BITS_FOR_INDEX-1:0] rowIndex;
    logic [BITS_FOR_INDEX-1:0] colIndex;
    logic [7:0]                DATA_R0;
    logic [7:0]                DATA_G0;
    logic [7:0]                DATA_B0;

    logic                      out_valid;
    logic                      out_ready;
    logic [BITS_FOR_INDEX-1:0] out_row;
    logic [BITS_FOR_INDEX-1:0] out_col;
    logic [7:0]                out_R;
    logic [7:0]                out_G;
    logic [7:0]                out_B;

    modport master (
        output in_valid, rowIndex, colIndex, DATA_R0, DATA_G0, DATA_B0,
        output out_ready,
        input  out_valid, out_row, out_col, out_R, out_G, out_B
    );

    modport slave (
        input  in_valid, rowIndex, colIndex, DATA_R0, DATA_G0, DATA_B0,
        input  out_ready,
        output out_valid, out_row, out_col, out_R, out_G, out_B
    );
endinterface

// File: rtl/frame_replay_buffer_frame_ram.sv
// Simple dual-port frame memory: one write port, one registered read port.
// Ports: clk; wr_en/wr_addr/wr_data write; rd_en/rd_addr read request,
// rd_data valid the cycle after rd_en.
module frame_ram
    import image_pkg::*;
#(
    parameter int DEPTH     = DEF_IMG_WIDTH * DEF_IMG_HEIGHT,
    parameter int ADDR_BITS = 19
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  rgb_t                 wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output rgb_t                 rd_data
);
    localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rgb_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[IDX_BITS-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr[IDX_BITS-1:0]];
        end
    end
endmodule

// File: rtl/frame_replay_buffer.sv
// Captures one RGB frame from an indexed pixel stream and replays it in
// raster order on a valid/ready stream.
// Ports: HCLK clock; HRESETn synchronous active-high reset;
//        bus (slave) pixel input + replay output stream;
//        start_replay request (honoured in FULL); capture_done level;
//        replay_done one-cycle pulse after the last pixel; idx_err sticky.
module frame_replay_buffer
    import image_pkg::*;
#(
    parameter int BITS_FOR_INDEX = 10,
    parameter int IMG_WIDTH      = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT     = DEF_IMG_HEIGHT,
    parameter int ADDR_BITS      = 19
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    frame_replay_buffer_if.slave  bus,
    input  logic                  start_replay,
    output logic                  capture_done,
    output logic                  replay_done,
    output logic                  idx_err
);
    localparam logic [BITS_FOR_INDEX-1:0] ROW_LIM  = BITS_FOR_INDEX'(IMG_HEIGHT);
    localparam logic [BITS_FOR_INDEX-1:0] COL_LIM  = BITS_FOR_INDEX'(IMG_WIDTH);
    localparam logic [BITS_FOR_INDEX-1:0] ROW_LAST = BITS_FOR_INDEX'(IMG_HEIGHT - 1);
    localparam logic [BITS_FOR_INDEX-1:0] COL_LAST = BITS_FOR_INDEX'(IMG_WIDTH - 1);

    function automatic logic [ADDR_BITS-1:0] pix_addr(input logic [BITS_FOR_INDEX-1:0] row,
                                                      input logic [BITS_FOR_INDEX-1:0] col);
        return ADDR_BITS'(row) * ADDR_BITS'(IMG_WIDTH) + ADDR_BITS'(col);
    endfunction

    state_t state, state_next;

    logic in_range, wr_en, frame_last_wr, xfer, last_xfer, rd_issue;
    logic [1:0] occ;

    // read-issue side
    logic [BITS_FOR_INDEX-1:0] rd_row, rd_col;
    logic                      rd_done;
    // RAM output stage (data for rq_row/rq_col is on rd_data)
    logic                      rq_valid;
    logic [BITS_FOR_INDEX-1:0] rq_row, rq_col;
    rgb_t                      rd_data;
    // skid register
    logic                      skid_valid;
    logic [BITS_FOR_INDEX-1:0] skid_row, skid_col;
    rgb_t                      skid_pix;
    // output register
    logic                      out_valid;
    logic [BITS_FOR_INDEX-1:0] out_row, out_col;
    rgb_t                      out_pix;

    assign in_range      = (bus.rowIndex < ROW_LIM) && (bus.colIndex < COL_LIM);
    assign wr_en         = (state == CAPTURE) && bus.in_valid && in_range;
    assign frame_last_wr = wr_en && (bus.rowIndex == ROW_LAST) && (bus.colIndex == COL_LAST);
    assign xfer          = out_valid && bus.out_ready;
    assign last_xfer     = xfer && (out_row == ROW_LAST) && (out_col == COL_LAST);

    // Pixels held or in flight never exceed the two slots (output + skid), so a
    // read is issued only if, after this cycle's transfer, at most one is left.
    assign occ      = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rq_valid};
    assign rd_issue = (state == REPLAY) && !rd_done && ((occ - {1'b0, xfer}) <= 2'd1);

    frame_ram #(
        .DEPTH    (IMG_WIDTH * IMG_HEIGHT),
        .ADDR_BITS(ADDR_BITS)
    ) u_frame_ram (
        .clk    (HCLK),
        .wr_en  (wr_en),
        .wr_addr(pix_addr(bus.rowIndex, bus.colIndex)),
        .wr_data({bus.DATA_R0, bus.DATA_G0, bus.DATA_B0}),
        .rd_en  (rd_issue),
        .rd_addr(pix_addr(rd_row, rd_col)),
        .rd_data(rd_data)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            CAPTURE: if (frame_last_wr) state_next = FULL;
            FULL:    if (start_replay)  state_next = REPLAY;
            REPLAY:  if (last_xfer)     state_next = CAPTURE;
            default: state_next = CAPTURE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            state <= CAPTURE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            capture_done <= 1'b0;
            replay_done  <= 1'b0;
            idx_err      <= 1'b0;
        end else begin
            capture_done <= (state_next != CAPTURE);
            replay_done  <= last_xfer;
            if ((state == CAPTURE) && bus.in_valid && !in_range) begin
                idx_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn || last_xfer) begin
            rd_row     <= '0;
            rd_col     <= '0;
            rd_done    <= 1'b0;
            rq_valid   <= 1'b0;
            rq_row     <= '0;
            rq_col     <= '0;
            skid_valid <= 1'b0;
            skid_row   <= '0;
            skid_col   <= '0;
            skid_pix   <= '0;
            out_valid  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            out_pix    <= '0;
        end else begin
            rq_valid <= rd_issue;
            if (rd_issue) begin
                rq_row <= rd_row;
                rq_col <= rd_col;
                if (rd_col == COL_LAST) begin
                    rd_col <= '0;
                    if (rd_row == ROW_LAST) begin
                        rd_done <= 1'b1;
                    end else begin
                        rd_row <= rd_row + 1'b1;
                    end
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end

            // Output slot frees up: refill from skid first (older), else from RAM.
            // While stalled, a pixel arriving from RAM parks in the skid register.
            if (!out_valid || xfer) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_row   <= skid_row;
                    out_col   <= skid_col;
                    out_pix   <= skid_pix;
                    if (rq_valid) begin
                        skid_row <= rq_row;
                        skid_col <= rq_col;
                        skid_pix <= rd_data;
                    end else begin
                        skid_valid <= 1'b0;
                    end
                end else if (rq_valid) begin
                    out_valid <= 1'b1;
                    out_row   <= rq_row;
                    out_col   <= rq_col;
                    out_pix   <= rd_data;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (rq_valid) begin
                skid_valid <= 1'b1;
                skid_row   <= rq_row;
                skid_col   <= rq_col;
                skid_pix   <= rd_data;
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_row   = out_row;
    assign bus.out_col   = out_col;
    assign bus.out_R     = out_pix.r;
    assign bus.out_G     = out_pix.g;
    assign bus.out_B     = out_pix.b;

endmodule

// File: tb/tb_frame_replay_buffer.sv
// Scoreboard bench for frame_replay_buffer on a 4x2 frame.
module tb_frame_replay_buffer;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int M_CAP    = 0;
    localparam int M_FULL   = 1;
    localparam int M_REPLAY = 2;

    logic clk = 1'b0;
    logic rst;
    logic start_replay;
    logic capture_done, replay_done, idx_err;

    frame_replay_buffer_if #(.BITS_FOR_INDEX(10)) bus ();

    frame_replay_buffer #(
        .BITS_FOR_INDEX(10),
        .IMG_WIDTH     (W),
        .IMG_HEIGHT    (H),
        .ADDR_BITS     (3)
    ) dut (
        .HCLK        (clk),
        .HRESETn     (rst),
        .bus         (bus),
        .start_replay(start_replay),
        .capture_done(capture_done),
        .replay_done (replay_done),
        .idx_err     (idx_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int xfer_cnt = 0;

    // behavioural model
    logic [23:0] model [W*H];
    int          mstate = M_CAP;
    logic        idx_exp = 1'b0;
    logic [43:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // monitor: pops expected pixel on every handshake, checks stall stability
    logic [43:0] cur, held, e;
    bit stalled = 1'b0;
    always @(negedge clk) begin
        if (bus.out_valid) begin
            cur = {bus.out_row, bus.out_col, bus.out_R, bus.out_G, bus.out_B};
            if (stalled) check("stall_stable", 64'(cur), 64'(held));
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_xfer: got %0h required no transfer", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", 64'(cur), 64'(e));
                end
                xfer_cnt++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = cur;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        start_replay = 1'b0;
        bus.out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        mstate = M_CAP;
        idx_exp = 1'b0;
        exp_q.delete();
        #3;
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_capture_done", 64'(capture_done), 0);
        check("rst_replay_done", 64'(replay_done), 0);
        check("rst_idx_err", 64'(idx_err), 0);
        check("rst_out_data", 64'({bus.out_row, bus.out_col, bus.out_R, bus.out_G, bus.out_B}), 0);
    endtask

    // one clock of input stimulus, model update, then post-edge status checks
    task automatic cycle_in(input bit v, input int r, input int c, input logic [23:0] pix, input bit sr);
        bus.in_valid = v;
        bus.rowIndex = 10'(r);
        bus.colIndex = 10'(c);
        {bus.DATA_R0, bus.DATA_G0, bus.DATA_B0} = pix;
        start_replay = sr;
        if (mstate == M_CAP) begin
            if (v) begin
                if (r < H && c < W) begin
                    model[r*W+c] = pix;
                    if (r == H-1 && c == W-1) mstate = M_FULL;
                end else begin
                    idx_exp = 1'b1;
                end
            end
        end else if (mstate == M_FULL && sr) begin
            mstate = M_REPLAY;
            for (int i = 0; i < W*H; i++) exp_q.push_back({10'(i / W), 10'(i % W), model[i]});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        start_replay = 1'b0;
        #3;
        check("idx_err", 64'(idx_err), 64'(idx_exp));
        if (mstate != M_REPLAY) begin
            check("capture_done", 64'(capture_done), 64'(mstate == M_FULL));
            check("out_valid_idle", 64'(bus.out_valid), 0);
        end
    endtask

    task automatic capture_raster_random();
        int order [W*H-1];
        int j, t;
        for (int i = 0; i < W*H-1; i++) order[i] = i;
        for (int i = W*H-2; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < W*H-1; i++)
            cycle_in(1'b1, order[i] / W, order[i] % W, 24'($urandom), 1'b0);
        cycle_in(1'b1, H-1, W-1, 24'($urandom), 1'b0);
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0, 2: random ready
    task automatic run_replay(input int mode);
        int first = -1;
        int done_seen = 0;
        int done_at = -1;
        int start_x = xfer_cnt;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (mode == 0) bus.out_ready = 1'b1;
            else if (mode == 1) bus.out_ready = (cyc % 3 == 0);
            else bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.out_valid && first < 0) first = cyc;
            if (replay_done) begin
                done_seen++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_seen > 0 && cyc >= done_at + 2) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        #3;
        check("first_valid_latency", 64'(first), 2);
        check("replay_done_pulses", 64'(done_seen), 1);
        check("transfers", 64'(xfer_cnt - start_x), 64'(W*H));
        check("queue_empty", 64'(exp_q.size()), 0);
        check("post_out_valid", 64'(bus.out_valid), 0);
        check("post_capture_done", 64'(capture_done), 0);
        if (mode == 0) check("full_rate_span", 64'(done_at - first), 64'(W*H));
        mstate = M_CAP;
    endtask

    initial begin
        logic [7:0] rv;
        int k;
        int s;
        bus.rowIndex = '0;
        bus.colIndex = '0;
        {bus.DATA_R0, bus.DATA_G0, bus.DATA_B0} = '0;

        // reset, then out-of-range row sets sticky idx_err
        do_reset(2);
        cycle_in(1'b1, H, 0, 24'($urandom), 1'b0);
        cycle_in(1'b0, 0, 0, 24'h0, 1'b0);
        cycle_in(1'b0, 0, 0, 24'h0, 1'b0);
        do_reset(1);

        // raster capture with fixed pattern, FULL ignores input, full-rate replay
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                rv = 8'(r*4 + c);
                cycle_in(1'b1, r, c, {rv, ~rv, 8'hA5}, 1'b0);
            end
        cycle_in(1'b1, 0, 0, 24'($urandom), 1'b0);
        cycle_in(1'b1, H, W, 24'($urandom), 1'b0);
        cycle_in(1'b0, 0, 0, 24'h0, 1'b1);
        run_replay(0);

        // shuffled capture, replay under 1,0,0 backpressure
        capture_raster_random();
        cycle_in(1'b0, 0, 0, 24'h0, 1'b1);
        run_replay(1);

        // out-of-range writes must not alias; single-pixel completion;
        // start_replay with the final write ignored; in_valid+start in FULL drops pixel
        cycle_in(1'b1, H, 0, 24'($urandom), 1'b0);
        cycle_in(1'b1, 0, W, 24'($urandom), 1'b0);
        cycle_in(1'b1, H-1, W-1, 24'($urandom), 1'b1);
        repeat (3) cycle_in(1'b0, 0, 0, 24'h0, 1'b0);
        cycle_in(1'b1, 0, 1, 24'($urandom), 1'b1);
        run_replay(2);

        // start_replay outside FULL ignored; rewrite of (0,0) wins
        cycle_in(1'b0, 0, 0, 24'h0, 1'b1);
        cycle_in(1'b0, 0, 0, 24'h0, 1'b0);
        for (int i = 0; i < W*H-1; i++) cycle_in(1'b1, i / W, i % W, 24'($urandom), 1'b0);
        cycle_in(1'b1, 0, 0, {8'h55, 16'($urandom)}, 1'b0);
        cycle_in(1'b1, H-1, W-1, 24'($urandom), 1'b0);
        cycle_in(1'b0, 0, 0, 24'h0, 1'b1);
        run_replay(0);

        // reset in the middle of a replay, then a fresh capture + replay
        capture_raster_random();
        cycle_in(1'b0, 0, 0, 24'h0, 1'b1);
        s = xfer_cnt;
        bus.out_ready = 1'b1;
        k = 0;
        while ((xfer_cnt - s) < 3 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("mid_reset_xfers", 64'((xfer_cnt - s) >= 3), 1);
        rst = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        mstate = M_CAP;
        idx_exp = 1'b0;
        exp_q.delete();
        #3;
        check("mid_reset_out_valid", 64'(bus.out_valid), 0);
        check("mid_reset_capture_done", 64'(capture_done), 0);
        check("mid_reset_replay_done", 64'(replay_done), 0);
        capture_raster_random();
        cycle_in(1'b0, 0, 0, 24'h0, 1'b1);
        run_replay(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_replay_buffer.md
Name: frame_replay_buffer

Overview:
- Captures one full RGB frame from the indexed pixel stream (rowIndex/colIndex + DATA_R0/G0/B0, as produced by the image-read/greyScale stage) into on-chip memory.
- Replays that frame in raster order on a valid/ready output stream.
- Acts as the receiving end of the image-read pixel interface and the transmitter toward downstream consumers (display, edge detection).

Parameters:
- BITS_FOR_INDEX, 10, width of row/col index ports
- IMG_WIDTH, 640, pixels per row
- IMG_HEIGHT, 480, rows per frame
- ADDR_BITS, 19, memory address width; must satisfy 2^ADDR_BITS >= IMG_WIDTH*IMG_HEIGHT

Ports:
- HCLK  in  1  clock, all logic on rising edge
- HRESETn  in  1  reset, synchronous, active-high; the name is kept for compatibility with the existing benches, which pulse it high
- in_valid  in  1  input pixel qualifier
- rowIndex  in  BITS_FOR_INDEX  input pixel row
- colIndex  in  BITS_FOR_INDEX  input pixel column
- DATA_R0, DATA_G0, DATA_B0  in  8 each  input pixel colour
- capture_done  out  1  level, frame fully captured
- start_replay  in  1  request replay (sampled only in FULL)
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accept
- out_row, out_col  out  BITS_FOR_INDEX each  output pixel coordinates
- out_R, out_G, out_B  out  8 each  output pixel colour
- replay_done  out  1  one-cycle pulse after last pixel accepted
- idx_err  out  1  sticky, out-of-range index seen

Behaviour:
- Reset (HRESETn=1 at a clock edge):
  - state=CAPTURE.
  - All outputs 0, including idx_err.
  - Replay counters 0. Memory contents are not cleared.
  - Reset mid-capture or mid-replay aborts immediately; the next cycle is CAPTURE.
- Memory: IMG_WIDTH*IMG_HEIGHT words x 24 bits {R,G,B}. Address = row*IMG_WIDTH + col, truncated to ADDR_BITS. Synchronous 1-cycle read.
- CAPTURE:
  - in_valid=1 with row<IMG_HEIGHT and col<IMG_WIDTH: write the pixel in that cycle.
  - Out-of-range index: no write; idx_err=1 from the next cycle until reset.
  - Write order is free and rewrites overwrite.
  - Frame completion trigger: a write at (IMG_HEIGHT-1, IMG_WIDTH-1). Next cycle: state=FULL, capture_done=1.
- FULL:
  - in_valid ignored (no writes, no idx_err update).
  - capture_done held at 1.
  - start_replay=1 -> REPLAY next cycle.
- REPLAY:
  - Raster counters start at (0,0). The first memory read is issued in the first REPLAY cycle.
  - out_valid rises 2 cycles after the start_replay edge.
  - Handshake: transfer when out_valid&&out_ready. While out_valid=1 and out_ready=0, all out_* stay stable.
  - Throughput is 1 pixel/cycle with out_ready held high. This requires read-ahead plus a 1-entry skid register; no bubbles after the first pixel.
  - Column wraps IMG_WIDTH-1 -> 0 with row+1.
  - Transfer of (IMG_HEIGHT-1, IMG_WIDTH-1): next cycle out_valid=0, replay_done=1 for exactly 1 cycle, capture_done=0, state=CAPTURE.
  - in_valid ignored during REPLAY.
- start_replay outside FULL: ignored.
- in_valid and start_replay in the same FULL cycle: replay starts; the pixel is dropped.
- Final capture write with start_replay asserted in the same cycle: start_replay ignored (state still CAPTURE).

Decomposition:
- Shared package (image_pkg):
  - IMG_WIDTH/IMG_HEIGHT defaults
  - rgb_t struct {r,g,b}
  - state enum {CAPTURE, FULL, REPLAY}
- One sub-module: frame_ram
  - Simple dual-port: 1 write port, 1 registered read port, 24-bit word, depth parameter.
  - Inferable as BRAM.
- The FSM, counters and skid register stay in the top module.

Test Plan:
- Reset/idle: HRESETn high 2 cycles -> all outputs 0, capture_done=0. Then in_valid with row=IMG_HEIGHT (480) -> idx_err=1 one cycle later and stays 1; no write.
- Full raster capture: IMG_WIDTH=4, IMG_HEIGHT=2; pixels (r,c) with R=r*4+c, G=~R, B=8'hA5 -> capture_done=1 the cycle after (1,3) is written.
- Replay at full rate: capture as above, start_replay, out_ready=1 -> out_valid 2 cycles later; 8 consecutive transfers (0,0)..(1,3) with matching data; replay_done one-cycle pulse; capture_done=0 after.
- Backpressure: out_ready toggling 1,0,0,1... -> each pixel appears exactly once, in order; out_* stable during stalls; total transfers=8.
- Out-of-order and overwrite: write (1,3) first -> capture_done=1 immediately. Rewrite (0,0) with R=8'h55 before completion in a second run -> replay shows 8'h55 at (0,0).
- Mid-replay reset: assert HRESETn after 3 transfers -> next cycle out_valid=0, state CAPTURE. A new full capture plus replay then succeeds with fresh data.
